// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and decode helpers for the iterative divider
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } divop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int CNT_W = 6;

    function automatic logic op_signed(input divop_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_rem(input divop_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - EX-stage handshake bundle between pipeline and divider
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    divop_t                divop;
    logic [DATA_WIDTH-1:0] opr_a;
    logic [DATA_WIDTH-1:0] opr_b;
    logic                  kill;
    logic                  busy;
    logic                  valid;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, divop, opr_a, opr_b, kill,
        input  busy, valid, result
    );

    modport slave (
        input  start, divop, opr_a, opr_b, kill,
        output busy, valid, result
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring division step (shift, trial subtract, select)
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out
);
    logic [W:0] trial;
    logic [W:0] diff;

    always_comb begin
        trial = {rem_in, quo_in[W-1]};
        diff  = trial - {1'b0, divisor};
        // Borrow out means the trial remainder is smaller than the divisor: restore.
        if (diff[W]) begin
            rem_out = trial[W-1:0];
            quo_out = {quo_in[W-2:0], 1'b0};
        end else begin
            rem_out = diff[W-1:0];
            quo_out = {quo_in[W-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed/unsigned divide and remainder unit for the EX stage
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     dsr_q;
    logic [W-1:0]     result_q;
    divop_t           op_q;
    logic             neg_q;
    logic             valid_q;

    logic [W-1:0] rem_nx;
    logic [W-1:0] quo_nx;

    logic         sign_a;
    logic         sign_b;
    logic [W-1:0] abs_a;
    logic [W-1:0] abs_b;
    logic         div_zero;
    logic         ovf;
    logic         special;
    logic [W-1:0] special_res;
    logic         neg_start;
    logic [W-1:0] raw_res;
    logic [W-1:0] fixed_res;

    div_step #(.W(W)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dsr_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_comb begin
        sign_a    = op_signed(bus.divop) & bus.opr_a[W-1];
        sign_b    = op_signed(bus.divop) & bus.opr_b[W-1];
        abs_a     = sign_a ? (~bus.opr_a + 1'b1) : bus.opr_a;
        abs_b     = sign_b ? (~bus.opr_b + 1'b1) : bus.opr_b;
        div_zero  = (bus.opr_b == '0);
        ovf       = op_signed(bus.divop) && (bus.opr_a == {1'b1, {(W-1){1'b0}}})
                    && (bus.opr_b == '1);
        special   = div_zero || ovf;
        // Quotient sign follows the operand signs; remainder follows the dividend.
        neg_start = op_rem(bus.divop) ? sign_a : (sign_a ^ sign_b);
        if (div_zero) begin
            special_res = op_rem(bus.divop) ? bus.opr_a : '1;
        end else begin
            special_res = op_rem(bus.divop) ? '0 : bus.opr_a;
        end
        raw_res   = op_rem(op_q) ? rem_nx : quo_nx;
        fixed_res = neg_q ? (~raw_res + 1'b1) : raw_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            op_q     <= DIVU;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.kill) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (special) begin
                                result_q <= special_res;
                                valid_q  <= 1'b1;
                                state    <= DONE;
                            end else begin
                                rem_q <= '0;
                                quo_q <= abs_a;
                                dsr_q <= abs_b;
                                op_q  <= bus.divop;
                                neg_q <= neg_start;
                                cnt   <= '0;
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            result_q <= fixed_res;
                            valid_q  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy   = ((state == IDLE) && bus.start && !bus.kill) || (state == CALC);
    assign bus.valid  = valid_q;
    assign bus.result = result_q;
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk  input  1  is the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  is a synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  means the EX stage holds a divide-class op this cycle.
REQ-005 SHALL have port divop  input  divop_t (2)  selects the operation: DIV, DIVU, REM or REMU.
REQ-006 SHALL have port opr_a  input  DATA_WIDTH  is the dividend (rs1 value).
REQ-007 SHALL have port opr_b  input  DATA_WIDTH  is the divisor (rs2 value).
REQ-008 SHALL have port kill  input  1  is a pipeline flush that aborts any operation in flight.
REQ-009 SHALL have port busy  output  1  is the stall request to the IF, ID and EX stages.
REQ-010 SHALL have port valid  output  1  is a one-cycle pulse meaning result is correct.
REQ-011 SHALL have port result  output  DATA_WIDTH  is the registered quotient or remainder.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-013 IDLE with start=1, kill=0 and a normal operand pair SHALL latch |opr_a|, |opr_b|, both signs and divop, clear the 6-bit iteration counter, and go to CALC.
REQ-014 IDLE with start=1, kill=0 and a special case (REQ-018 or REQ-019) SHALL load the final result directly and go to DONE.
REQ-015 CALC SHALL perform one radix-2 restoring step per cycle (shift the remainder left, trial-subtract, set the quotient bit) and go to DONE after exactly DATA_WIDTH cycles.
REQ-016 DONE SHALL assert valid=1 and drive the sign-corrected result, then return to IDLE unconditionally; start is ignored in DONE.
REQ-017 Sign correction: quotient is negated when operand signs differ (DIV only); remainder takes the dividend's sign (REM only); DIVU and REMU are uncorrected.
REQ-018 Divisor zero: DIV and DIVU SHALL return all-ones; REM and REMU SHALL return opr_a.
REQ-019 Signed overflow (opr_a = most-negative, opr_b = -1): DIV SHALL return opr_a; REM SHALL return 0.
REQ-020 busy SHALL be combinational: 1 when (state==IDLE and start and not kill) or state==CALC; 0 in DONE so the instruction advances in the valid cycle.
REQ-021 Latency, with start accepted in cycle 0: normal ops give valid in cycle DATA_WIDTH+1 (33); special cases give valid in cycle 1.
REQ-022 kill in any state SHALL force IDLE on the next edge with no valid pulse; kill together with start in IDLE SHALL NOT start an operation.
REQ-023 Operand and divop changes after acceptance SHALL NOT affect the result.
REQ-024 result SHALL hold its last value outside DONE; only valid qualifies it.
REQ-025 Back-to-back ops are permitted: start in the IDLE cycle right after DONE SHALL be accepted.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, result 0, valid 0 and busy 0 on the next edge, overriding start and kill, including mid-CALC.

Structure
REQ-027 divop_t (DIV, DIVU, REM, REMU) and the FSM state enum SHALL reside in a shared package div_unit_pkg, next to alu_pkg.
REQ-028 The single iteration step (shift, subtract, select) SHALL be a combinational sub-module div_step.
REQ-029 EX SHALL OR busy into the pipeline stall and select result over the ALU output when valid=1.

Verification
REQ-030 DIVU with opr_a=100 and opr_b=7 SHALL give valid in cycle 33 with result=14, and busy high in cycles 0..32.
REQ-031 REM with opr_a=-100 and opr_b=7 SHALL give result=-2 (0xFFFFFFFE); DIV with the same operands SHALL give result=-14.
REQ-032 DIV with opr_b=0 SHALL give valid in cycle 1 with result=0xFFFFFFFF; REMU with opr_a=5 and opr_b=0 SHALL give result=5.
REQ-033 DIV with opr_a=0x80000000 and opr_b=-1 SHALL give 0x80000000 in cycle 1; REM with the same operands SHALL give 0.
REQ-034 kill asserted in cycle 10 of an operation SHALL give IDLE and busy=0 in cycle 11, no valid pulse, and a subsequent DIVU 9/3 SHALL return 3.
REQ-035 rst asserted in cycle 20 of CALC SHALL make all outputs 0 in the next cycle, and back-to-back DIVU ops started in cycles 0 and 34 SHALL both return correct results.
